// File: rtl/memory_read_arbiter.sv
// Round-robin arbiter folding NCHANNELS one-deep read request slots onto a single downstream
// read engine, with a cont-lock that keeps merged transfers on the channel that started them.
module memory_read_arbiter #(
  parameter int unsigned NCHANNELS  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  localparam int unsigned CH_WIDTH  = (NCHANNELS > 1) ? $clog2(NCHANNELS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NCHANNELS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NCHANNELS*LEN_WIDTH-1:0]  m_len,
  input  logic [NCHANNELS-1:0]            m_start,
  input  logic [NCHANNELS-1:0]            m_cont,
  output logic [NCHANNELS-1:0]            m_busy,
  output logic [NCHANNELS-1:0]            m_done,
  output logic [NCHANNELS-1:0]            m_error,
  output logic [ADDR_WIDTH-1:0]           s_addr,
  output logic [LEN_WIDTH-1:0]            s_len,
  output logic                            s_start,
  output logic                            s_cont,
  input  logic                            s_busy,
  input  logic                            s_done,
  input  logic                            s_error,
  output logic [CH_WIDTH-1:0]             grant_id,
  output logic                            locked
);
  localparam int unsigned CW1 = CH_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                                 state_q, state_d;
  logic [NCHANNELS-1:0]                   pending_q, pending_d;
  logic [NCHANNELS-1:0][ADDR_WIDTH-1:0]   slot_addr_q, slot_addr_d;
  logic [NCHANNELS-1:0][LEN_WIDTH-1:0]    slot_len_q, slot_len_d;
  logic [NCHANNELS-1:0]                   slot_cont_q, slot_cont_d;
  logic [CH_WIDTH-1:0]                    rr_q, rr_d;
  logic [CH_WIDTH-1:0]                    grant_q, grant_d;
  logic [CH_WIDTH-1:0]                    lock_ch_q, lock_ch_d;
  logic                                   lock_q, lock_d;
  logic [ADDR_WIDTH-1:0]                  s_addr_q, s_addr_d;
  logic [LEN_WIDTH-1:0]                   s_len_q, s_len_d;
  logic                                   s_cont_q, s_cont_d;
  logic [NCHANNELS-1:0]                   busy_q, busy_d;
  logic [NCHANNELS-1:0]                   done_q, done_d;
  logic [NCHANNELS-1:0]                   err_q, err_d;

  logic [NCHANNELS-1:0]                   lock_mask;
  logic [NCHANNELS-1:0]                   eligible;
  logic                                   found;
  logic [CH_WIDTH-1:0]                    pick;
  logic [CW1-1:0]                         idx;

  // First eligible channel at or after the round-robin pointer, wrapping
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_ch_q] = 1'b1;
    eligible             = lock_q ? (pending_q & lock_mask) : pending_q;
    found                = 1'b0;
    pick                 = '0;
    idx                  = '0;
    for (int unsigned k = 0; k < NCHANNELS; k++) begin
      idx = CW1'(rr_q) + CW1'(k);
      if (idx >= CW1'(NCHANNELS)) idx = idx - CW1'(NCHANNELS);
      if (!found && eligible[idx[CH_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = idx[CH_WIDTH-1:0];
      end
    end
  end

  // Request capture, grant FSM and completion routing
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    slot_addr_d = slot_addr_q;
    slot_len_d  = slot_len_q;
    slot_cont_d = slot_cont_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    s_addr_d    = s_addr_q;
    s_len_d     = s_len_q;
    s_cont_d    = s_cont_q;
    done_d      = '0;
    err_d       = '0;
    busy_d      = '0;

    for (int unsigned i = 0; i < NCHANNELS; i++) begin
      if (m_start[i] && !busy_q[i]) begin
        pending_d[i]   = 1'b1;
        slot_addr_d[i] = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        slot_len_d[i]  = m_len[i*LEN_WIDTH +: LEN_WIDTH];
        slot_cont_d[i] = m_cont[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          s_addr_d = slot_addr_q[pick];
          s_len_d  = slot_len_q[pick];
          s_cont_d = slot_cont_q[pick];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!s_busy) begin
          pending_d[grant_q] = 1'b0;
          state_d            = WAIT;
        end
      end
      WAIT: begin
        if (s_done) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = s_error;
          rr_d            = (grant_q == CH_WIDTH'(NCHANNELS - 1)) ? '0 : grant_q + CH_WIDTH'(1);
          lock_d          = s_cont_q;
          lock_ch_d       = grant_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy covers the queued slot and the channel owning the in-flight transfer
    for (int unsigned i = 0; i < NCHANNELS; i++) begin
      busy_d[i] = pending_d[i] | ((state_d != IDLE) && (grant_d == CH_WIDTH'(i)));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      slot_addr_q <= '0;
      slot_len_q  <= '0;
      slot_cont_q <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      s_addr_q    <= '0;
      s_len_q     <= '0;
      s_cont_q    <= 1'b0;
      busy_q      <= '0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      slot_addr_q <= slot_addr_d;
      slot_len_q  <= slot_len_d;
      slot_cont_q <= slot_cont_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      s_addr_q    <= s_addr_d;
      s_len_q     <= s_len_d;
      s_cont_q    <= s_cont_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // The strobe is the ISSUE-state handshake with the engine, so it follows s_busy directly
  assign s_start  = (state_q == ISSUE) && !s_busy;
  assign m_busy   = busy_q;
  assign m_done   = done_q;
  assign m_error  = err_q;
  assign s_addr   = s_addr_q;
  assign s_len    = s_len_q;
  assign s_cont   = s_cont_q;
  assign grant_id = grant_q;
  assign locked   = lock_q;

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Bench for memory_read_arbiter: directed scenarios plus randomized batches checked against
// a transaction-level round-robin/lock model.
module tb_memory_read_arbiter;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 16;
  localparam int unsigned CW  = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NCH*AW-1:0]   m_addr;
  logic [NCH*LW-1:0]   m_len;
  logic [NCH-1:0]      m_start;
  logic [NCH-1:0]      m_cont;
  logic [NCH-1:0]      m_busy;
  logic [NCH-1:0]      m_done;
  logic [NCH-1:0]      m_error;
  logic [AW-1:0]       s_addr;
  logic [LW-1:0]       s_len;
  logic                s_start;
  logic                s_cont;
  logic                s_busy;
  logic                s_done;
  logic                s_error;
  logic [CW-1:0]       grant_id;
  logic                locked;

  int n_cmp  = 0;
  int n_fail = 0;

  memory_read_arbiter #(.NCHANNELS(NCH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clock(clock), .reset(reset),
    .m_addr(m_addr), .m_len(m_len), .m_start(m_start), .m_cont(m_cont),
    .m_busy(m_busy), .m_done(m_done), .m_error(m_error),
    .s_addr(s_addr), .s_len(s_len), .s_start(s_start), .s_cont(s_cont),
    .s_busy(s_busy), .s_done(s_done), .s_error(s_error),
    .grant_id(grant_id), .locked(locked)
  );

  always #5 clock = ~clock;

  // One cycle: inputs change just after the falling edge, pulses last one cycle
  task automatic step();
    @(negedge clock);
    m_start = '0;
    s_done  = 1'b0;
    s_error = 1'b0;
    #1;
  endtask

  task automatic set_busy(input logic b);
    s_busy = b;
    #1;
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] l,
                         input logic c);
    m_addr[ch*AW +: AW] = a;
    m_len[ch*LW +: LW]  = l;
    m_cont[ch]          = c;
    m_start[ch]         = 1'b1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    m_start = '0;
    s_done  = 1'b0;
    s_error = 1'b0;
    s_busy  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_sstart(input int max, output int lat, output bit ok);
    lat = 0;
    while (!s_start && lat < max) begin
      step();
      lat++;
    end
    ok = s_start;
  endtask

  // From the s_start cycle: let the strobe land, return s_done, stop on the m_done cycle
  task automatic complete(input logic err);
    step();
    s_done  = 1'b1;
    s_error = err;
    step();
  endtask

  function automatic int model_pick(input bit [NCH-1:0] pend, input int rr, input bit lk,
                                    input int lch);
    for (int k = 0; k < NCH; k++) begin
      int c = (rr + k) % NCH;
      if (pend[c] && (!lk || c == lch)) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({m_busy, m_done, m_error, s_addr, s_len, s_start, s_cont, grant_id, locked} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b addr=%h len=%h start=%b cont=%b gid=%0d lock=%b, want all 0",
               m_busy, m_done, m_error, s_addr, s_len, s_start, s_cont, grant_id, locked);
    end
  endtask

  task automatic test_single();
    int lat; bit ok;
    do_reset();
    set_req(2, 32'h1000, 16'd64, 1'b0);
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || lat != 2) begin
      n_fail++; $display("FAIL single_latency: got ok=%b lat=%0d, want 1/2", ok, lat);
    end
    n_cmp++;
    if (s_addr !== 32'h1000 || s_len !== 16'd64 || grant_id !== 2'd2 || s_cont !== 1'b0) begin
      n_fail++;
      $display("FAIL single_fields: got addr=%h len=%0d gid=%0d cont=%b, want 1000/64/2/0",
               s_addr, s_len, grant_id, s_cont);
    end
    n_cmp++;
    if (m_busy !== 4'b0100) begin
      n_fail++; $display("FAIL single_busy: got %b want 0100", m_busy);
    end
    complete(1'b0);
    n_cmp++;
    if (m_done !== 4'b0100 || m_error !== 4'b0000 || m_busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done: got done=%b err=%b busy=%b, want 0100/0000/0000",
               m_done, m_error, m_busy);
    end
    step();
    n_cmp++;
    if (m_done !== 4'b0000) begin
      n_fail++; $display("FAIL single_done_pulse: got %b want 0000", m_done);
    end
  endtask

  task automatic test_round_robin();
    int lat; bit ok;
    do_reset();
    for (int ch = 0; ch < NCH; ch++) set_req(ch, AW'(32'h2000 + ch * 16), LW'(16 + ch), 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NCH; k++) begin
        wait_sstart(20, lat, ok);
        n_cmp++;
        if (!ok || grant_id !== CW'(k) || s_addr !== AW'(32'h2000 + r * 256 + k * 16)) begin
          n_fail++;
          $display("FAIL rr_order round %0d slot %0d: got ok=%b gid=%0d addr=%h, want gid=%0d addr=%h",
                   r, k, ok, grant_id, s_addr, k, 32'h2000 + r * 256 + k * 16);
        end
        complete(1'b0);
        n_cmp++;
        if (m_done !== NCH'(1 << k)) begin
          n_fail++; $display("FAIL rr_done slot %0d: got %b want %b", k, m_done, NCH'(1 << k));
        end
        if (r == 0 && k == NCH - 1) begin
          for (int ch = 0; ch < NCH; ch++)
            set_req(ch, AW'(32'h2100 + ch * 16), LW'(32 + ch), 1'b0);
        end
      end
    end
  endtask

  task automatic test_lock();
    int lat; bit ok; int starts;
    do_reset();
    set_req(1, 32'h3000, 16'd32, 1'b1);
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd1 || s_cont !== 1'b1) begin
      n_fail++; $display("FAIL lock_first: got ok=%b gid=%0d cont=%b, want 1/1/1", ok, grant_id, s_cont);
    end
    step();
    set_req(0, 32'h3100, 16'd8, 1'b0);
    set_req(3, 32'h3300, 16'd8, 1'b0);
    s_done = 1'b1;
    step();
    n_cmp++;
    if (m_done !== 4'b0010 || locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_set: got done=%b locked=%b, want 0010/1", m_done, locked);
    end
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_start) starts++;
    end
    n_cmp++;
    if (starts != 0 || m_busy !== 4'b1001) begin
      n_fail++; $display("FAIL lock_starve: got starts=%0d busy=%b, want 0/1001", starts, m_busy);
    end
    set_req(1, 32'h3010, 16'd16, 1'b0);
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd1 || s_addr !== 32'h3010 || s_cont !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_second: got ok=%b gid=%0d addr=%h cont=%b, want 1/1/3010/0",
               ok, grant_id, s_addr, s_cont);
    end
    complete(1'b0);
    n_cmp++;
    if (m_done !== 4'b0010 || locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_clear: got done=%b locked=%b, want 0010/0", m_done, locked);
    end
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd3 || s_addr !== 32'h3300) begin
      n_fail++; $display("FAIL lock_after_a: got ok=%b gid=%0d addr=%h, want 1/3/3300", ok, grant_id, s_addr);
    end
    complete(1'b0);
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || grant_id !== 2'd0 || s_addr !== 32'h3100) begin
      n_fail++; $display("FAIL lock_after_b: got ok=%b gid=%0d addr=%h, want 1/0/3100", ok, grant_id, s_addr);
    end
    complete(1'b0);
  endtask

  task automatic test_backpressure_error();
    int starts; bit stable;
    do_reset();
    set_busy(1'b1);
    set_req(0, 32'h4000, 16'd128, 1'b0);
    step();
    step();
    starts = 0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (s_start) starts++;
      if (s_addr !== 32'h4000 || s_len !== 16'd128 || grant_id !== 2'd0) stable = 1'b0;
      step();
    end
    set_busy(1'b0);
    n_cmp++;
    if (starts != 0 || !stable || s_start !== 1'b1 || s_addr !== 32'h4000) begin
      n_fail++;
      $display("FAIL bp_hold: got starts=%0d stable=%b start=%b addr=%h, want 0/1/1/4000",
               starts, stable, s_start, s_addr);
    end
    complete(1'b1);
    n_cmp++;
    if (m_done !== 4'b0001 || m_error !== 4'b0001) begin
      n_fail++; $display("FAIL bp_error: got done=%b err=%b, want 0001/0001", m_done, m_error);
    end
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_start) starts++;
    end
    n_cmp++;
    if (starts != 0) begin
      n_fail++; $display("FAIL bp_single_start: got %0d extra starts want 0", starts);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; int starts;
    do_reset();
    set_req(0, 32'h5000, 16'd4, 1'b1);
    set_req(1, 32'h5100, 16'd4, 1'b0);
    set_req(2, 32'h5200, 16'd4, 1'b0);
    wait_sstart(10, lat, ok);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({m_busy, m_done, m_error, s_addr, s_len, s_start, s_cont, grant_id, locked} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b addr=%h len=%h start=%b gid=%0d lock=%b, want all 0",
               m_busy, m_done, s_addr, s_len, s_start, grant_id, locked);
    end
    s_done = 1'b1;
    s_error = 1'b1;
    step();
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (s_start) starts++;
      step();
    end
    n_cmp++;
    if (m_done !== 4'b0000 || m_error !== 4'b0000 || starts != 0 || m_busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_stale: got done=%b err=%b starts=%0d busy=%b, want 0/0/0/0",
               m_done, m_error, starts, m_busy);
    end
    set_req(3, 32'h5300, 16'd12, 1'b0);
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || lat != 2 || grant_id !== 2'd3 || s_addr !== 32'h5300) begin
      n_fail++; $display("FAIL midreset_new: got ok=%b lat=%0d gid=%0d addr=%h, want 1/2/3/5300",
                         ok, lat, grant_id, s_addr);
    end
    complete(1'b0);
    n_cmp++;
    if (m_done !== 4'b1000 || m_error !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_done: got done=%b err=%b, want 1000/0000", m_done, m_error);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; bit ok;
    do_reset();
    set_req(0, 32'h6000, 16'd20, 1'b0);
    step();
    set_req(0, 32'h6666, 16'd99, 1'b1);
    n_cmp++;
    if (m_busy !== 4'b0001) begin
      n_fail++; $display("FAIL ignore_busy: got %b want 0001", m_busy);
    end
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || lat != 1 || s_addr !== 32'h6000 || s_len !== 16'd20 || s_cont !== 1'b0) begin
      n_fail++; $display("FAIL ignore_fields: got ok=%b lat=%0d addr=%h len=%0d cont=%b, want 1/1/6000/20/0",
                         ok, lat, s_addr, s_len, s_cont);
    end
    complete(1'b0);
    n_cmp++;
    if (m_done !== 4'b0001 || m_busy !== 4'b0000) begin
      n_fail++; $display("FAIL ignore_done: got done=%b busy=%b, want 0001/0000", m_done, m_busy);
    end
    set_req(0, 32'h6100, 16'd24, 1'b0);
    wait_sstart(10, lat, ok);
    n_cmp++;
    if (!ok || lat != 2 || s_addr !== 32'h6100 || s_len !== 16'd24) begin
      n_fail++; $display("FAIL back_to_back: got ok=%b lat=%0d addr=%h len=%0d, want 1/2/6100/24",
                         ok, lat, s_addr, s_len);
    end
    complete(1'b0);
  endtask

  task automatic test_random();
    logic [AW-1:0]  q_addr [NCH];
    logic [LW-1:0]  q_len  [NCH];
    bit             q_cont [NCH];
    bit [NCH-1:0]   pend, active, was, exp_vec;
    int  rr, lch, infl_ch, cd, exp_ch, cyc, want;
    bit  lk, infl, infl_cont, exp_done, exp_err, exp_cont;
    do_reset();
    pend = '0; active = '0; rr = 0; lk = 0; lch = 0;
    infl = 0; infl_ch = 0; infl_cont = 0; cd = 0;
    exp_done = 0; exp_ch = 0; exp_err = 0; exp_cont = 0;
    for (int b = 0; b < 30; b++) begin
      bit [NCH-1:0] mask = NCH'($urandom_range(1, 15));
      for (int ch = 0; ch < NCH; ch++) begin
        if (mask[ch]) begin
          q_addr[ch] = AW'($urandom);
          q_len[ch]  = LW'($urandom);
          q_cont[ch] = ($urandom_range(0, 3) == 0);
          set_req(ch, q_addr[ch], q_len[ch], q_cont[ch]);
          pend[ch] = 1'b1; active[ch] = 1'b1;
        end
      end
      cyc = 0;
      while ((pend != 0 || infl || exp_done || active != 0) && cyc < 400) begin
        was = active;
        step();
        cyc++;
        set_busy($urandom_range(0, 2) == 0);
        exp_vec = exp_done ? NCH'(1 << exp_ch) : '0;
        n_cmp++;
        if (m_done !== exp_vec || (exp_done && m_error !== (exp_err ? exp_vec : '0))) begin
          n_fail++; $display("FAIL rnd_done batch %0d: got done=%b err=%b, want done=%b err=%b",
                             b, m_done, m_error, exp_vec, exp_err ? exp_vec : '0);
        end
        if (exp_done) begin
          active[exp_ch] = 1'b0;
          rr = (exp_ch + 1) % NCH;
          lk = exp_cont;
          lch = exp_ch;
          exp_done = 0;
        end
        n_cmp++;
        if (m_busy !== active || locked !== lk) begin
          n_fail++; $display("FAIL rnd_busy batch %0d: got busy=%b lock=%b, want %b/%b",
                             b, m_busy, locked, active, lk);
        end
        if (lk && !active[lch]) begin
          q_addr[lch] = AW'($urandom);
          q_len[lch]  = LW'($urandom);
          q_cont[lch] = ($urandom_range(0, 2) == 0);
          set_req(lch, q_addr[lch], q_len[lch], q_cont[lch]);
          pend[lch] = 1'b1; active[lch] = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) begin
          int sc = $urandom_range(0, NCH - 1);
          if (was[sc] && active[sc] && !m_start[sc]) begin
            m_addr[sc*AW +: AW] = AW'($urandom);
            m_len[sc*LW +: LW]  = LW'($urandom);
            m_cont[sc]          = 1'b1;
            m_start[sc]         = 1'b1;
          end
        end
        if (infl) begin
          if (cd == 0) begin
            s_done = 1'b1; s_error = $urandom_range(0, 1) == 1;
            exp_done = 1; exp_ch = infl_ch; exp_err = s_error; exp_cont = infl_cont;
            infl = 0;
          end else cd--;
        end
        if (s_start) begin
          want = model_pick(pend, rr, lk, lch);
          n_cmp++;
          if (infl || exp_done || want < 0 || grant_id !== CW'(want) || s_addr !== q_addr[want] ||
              s_len !== q_len[want] || s_cont !== q_cont[want]) begin
            n_fail++;
            $display("FAIL rnd_grant batch %0d: got gid=%0d addr=%h len=%h cont=%b, want ch %0d (outstanding=%b)",
                     b, grant_id, s_addr, s_len, s_cont, want, infl | exp_done);
          end
          if (want >= 0) begin
            pend[want] = 1'b0; infl = 1; infl_ch = want; infl_cont = q_cont[want];
            cd = $urandom_range(1, 4);
          end
        end
      end
      n_cmp++;
      if (cyc >= 400) begin
        n_fail++; $display("FAIL rnd_timeout batch %0d: got pend=%b active=%b after %0d cycles", b, pend, active, cyc);
        pend = '0; active = '0; infl = 0; exp_done = 0;
        do_reset();
        rr = 0; lk = 0;
      end
    end
    set_busy(1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    m_addr  = '0;
    m_len   = '0;
    m_start = '0;
    m_cont  = '0;
    s_busy  = 1'b0;
    s_done  = 1'b0;
    s_error = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_backpressure_error();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
